// File: rtl/cmd_deserializer.sv
// SD card CMD-line response receiver: waits for the start bit under an NCR timeout,
// shifts in a 48- or 136-bit response and checks its CRC7 and end bit.
module cmd_deserializer #(
    parameter int SHORT_BITS      = 48,
    parameter int LONG_BITS       = 136,
    parameter int BITS_COUNTER    = 8,
    parameter int TIMEOUT         = 64,
    parameter int TIMEOUT_COUNTER = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 long_resp,
    input  logic                 in,
    output logic [LONG_BITS-1:0] out,
    output logic                 complete,
    output logic                 crc_ok,
    output logic                 end_ok,
    output logic                 timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

    // The R2 header (start, transmission and reserved index bits) lies outside the CRC.
    localparam int LONG_HDR = LONG_BITS - 128;

    state_t                     state, state_n;
    logic                       long_q, long_n;
    logic [BITS_COUNTER-1:0]    bit_cnt, bit_cnt_n;
    logic [TIMEOUT_COUNTER-1:0] tmo_cnt, tmo_cnt_n;
    logic [6:0]                 crc, crc_n;
    logic [LONG_BITS-1:0]       out_n;
    logic                       complete_n, crc_ok_n, end_ok_n, timeout_n;
    logic [BITS_COUNTER-1:0]    last_cnt;
    logic                       crc_en;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign last_cnt = long_q ? BITS_COUNTER'(LONG_BITS - 1) : BITS_COUNTER'(SHORT_BITS - 1);
    assign crc_en   = (bit_cnt <= last_cnt - BITS_COUNTER'(8)) &&
                      (!long_q || bit_cnt >= BITS_COUNTER'(LONG_HDR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            long_q   <= 1'b0;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            crc      <= '0;
            out      <= '0;
            complete <= 1'b0;
            crc_ok   <= 1'b0;
            end_ok   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            long_q   <= long_n;
            bit_cnt  <= bit_cnt_n;
            tmo_cnt  <= tmo_cnt_n;
            crc      <= crc_n;
            out      <= out_n;
            complete <= complete_n;
            crc_ok   <= crc_ok_n;
            end_ok   <= end_ok_n;
            timeout  <= timeout_n;
        end
    end

    always_comb begin
        state_n    = state;
        long_n     = long_q;
        bit_cnt_n  = bit_cnt;
        tmo_cnt_n  = tmo_cnt;
        crc_n      = crc;
        out_n      = out;
        complete_n = complete;
        crc_ok_n   = crc_ok;
        end_ok_n   = end_ok;
        timeout_n  = timeout;

        case (state)
            IDLE, DONE: begin
                if (enable) begin
                    state_n    = WAIT_START;
                    long_n     = long_resp;
                    bit_cnt_n  = '0;
                    tmo_cnt_n  = '0;
                    crc_n      = '0;
                    out_n      = '0;
                    complete_n = 1'b0;
                    crc_ok_n   = 1'b0;
                    end_ok_n   = 1'b0;
                    timeout_n  = 1'b0;
                end
            end
            // A start bit on the last allowed edge beats the timeout.
            WAIT_START: begin
                if (!in) begin
                    state_n   = RECEIVE;
                    out_n     = {out[LONG_BITS-2:0], in};
                    bit_cnt_n = BITS_COUNTER'(1);
                    crc_n     = long_q ? crc : crc7_step(crc, in);
                end else if (tmo_cnt == TIMEOUT_COUNTER'(TIMEOUT - 1)) begin
                    state_n    = DONE;
                    tmo_cnt_n  = TIMEOUT_COUNTER'(TIMEOUT);
                    timeout_n  = 1'b1;
                    complete_n = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + TIMEOUT_COUNTER'(1);
                end
            end
            RECEIVE: begin
                out_n     = {out[LONG_BITS-2:0], in};
                bit_cnt_n = bit_cnt + BITS_COUNTER'(1);
                if (crc_en) begin
                    crc_n = crc7_step(crc, in);
                end
                // On the end-bit edge out[6:0] already holds received CRC bits 7..1.
                if (bit_cnt == last_cnt) begin
                    state_n    = DONE;
                    end_ok_n   = in;
                    crc_ok_n   = (out[6:0] == crc);
                    complete_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmd_deserializer.sv
// Randomized self-checking bench for cmd_deserializer against a polynomial-division model.
module tb_cmd_deserializer;

    localparam int SB = 48;
    localparam int LB = 136;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          long_resp;
    logic          in;
    logic [LB-1:0] out;
    logic          complete, crc_ok, end_ok, timeout;

    int compared   = 0;
    int mismatched = 0;

    cmd_deserializer #(
        .SHORT_BITS(SB), .LONG_BITS(LB), .BITS_COUNTER(8),
        .TIMEOUT(64), .TIMEOUT_COUNTER(7)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .long_resp(long_resp), .in(in),
        .out(out), .complete(complete), .crc_ok(crc_ok), .end_ok(end_ok), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, by long division.
    function automatic logic [6:0] refCrc(input logic [LB-1:0] s, input bit isLong);
        logic [7:0] rem;
        int top;
        rem = '0;
        top = isLong ? 127 : SB - 1;
        for (int i = top; i >= 8; i--) begin
            rem = {rem[6:0], s[i]};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        for (int i = 0; i < 7; i++) begin
            rem = {rem[6:0], 1'b0};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arms the receiver, idles, then streams N bits MSB first; optional enable glitch mid-stream.
    task automatic applyStimulus(input logic [LB-1:0] s, input bit isLong, input int idle, input int glitchAt);
        int n;
        n = isLong ? LB : SB;
        @(negedge clk);
        enable    = 1'b1;
        long_resp = isLong;
        in        = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (idle) begin
            long_resp = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        for (int i = n - 1; i >= 0; i--) begin
            in        = s[i];
            enable    = (i == n - 1 - glitchAt);
            long_resp = 1'($urandom_range(0, 1));
            if (i == 0) checkOutput("complete_before_end", complete, 0);
            @(negedge clk);
            enable = 1'b0;
        end
    endtask

    task automatic checkResult(input logic [LB-1:0] s, input bit isLong);
        logic [LB-1:0] expOut;
        expOut = s;
        if (!isLong) expOut[LB-1:SB] = '0;
        checkOutput("complete", complete, 1);
        checkOutput("timeout", timeout, 0);
        checkOutput("out", out, expOut);
        checkOutput("crc_ok", crc_ok, (s[7:1] == refCrc(s, isLong)) ? 1 : 0);
        checkOutput("end_ok", end_ok, s[0]);
        repeat (3) begin
            in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput("out_hold", out, expOut);
        checkOutput("complete_hold", complete, 1);
        in = 1'b1;
    endtask

    function automatic logic [LB-1:0] makeShort();
        logic [LB-1:0] s;
        s = '0;
        s[SB-1:SB-2] = 2'b00;
        s[45:40] = 6'($urandom_range(0, 63));
        s[39:8]  = $urandom;
        s[7:1]   = refCrc(s, 1'b0);
        s[0]     = 1'b1;
        return s;
    endfunction

    function automatic logic [LB-1:0] makeLong();
        logic [LB-1:0] s;
        s = '0;
        s[135:128] = 8'h3F;
        for (int i = 8; i < 128; i++) s[i] = 1'($urandom_range(0, 1));
        s[7:1] = refCrc(s, 1'b1);
        s[0]   = 1'b1;
        return s;
    endfunction

    initial begin
        logic [LB-1:0] s;
        bit            isLong;
        int            mode;
        int            pos;

        reset = 1'b0; enable = 1'b0; long_resp = 1'b0; in = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_out", out, 0);
        checkOutput("rst_complete", complete, 0);
        checkOutput("rst_crc_ok", crc_ok, 0);
        checkOutput("rst_end_ok", end_ok, 0);
        checkOutput("rst_timeout", timeout, 0);
        reset = 1'b1;
        in    = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_no_arm_complete", complete, 0);
        checkOutput("idle_no_arm_out", out, 0);
        in = 1'b1;

        s = 136'h48000001AA87;
        applyStimulus(s, 1'b0, 5, -1);
        checkResult(s, 1'b0);
        checkOutput("r7_crc_lit", crc_ok, 1);

        s = 136'h48000001AA89;
        applyStimulus(s, 1'b0, 2, -1);
        checkResult(s, 1'b0);
        checkOutput("crcerr_lit", crc_ok, 0);

        s = 136'h48000001AA86;
        applyStimulus(s, 1'b0, 0, -1);
        checkResult(s, 1'b0);
        checkOutput("enderr_crc_lit", crc_ok, 1);
        checkOutput("enderr_end_lit", end_ok, 0);

        @(negedge clk);
        enable = 1'b1; long_resp = 1'($urandom_range(0, 1)); in = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (63) @(negedge clk);
        checkOutput("tmo_early_complete", complete, 0);
        @(negedge clk);
        checkOutput("tmo_complete", complete, 1);
        checkOutput("tmo_flag", timeout, 1);
        checkOutput("tmo_out", out, 0);

        s = 136'h48000001AA87;
        applyStimulus(s, 1'b0, 63, -1);
        checkResult(s, 1'b0);

        s = makeLong();
        applyStimulus(s, 1'b1, 3, -1);
        checkResult(s, 1'b1);
        checkOutput("r2_crc_lit", crc_ok, 1);
        s[60] = ~s[60];
        applyStimulus(s, 1'b1, 1, -1);
        checkResult(s, 1'b1);
        checkOutput("r2_flip_crc_lit", crc_ok, 0);

        s = 136'h48000001AA87;
        @(negedge clk);
        enable = 1'b1; long_resp = 1'b0; in = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = SB - 1; i >= SB - 20; i--) begin
            in = s[i];
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checkOutput("midrst_out", out, 0);
        checkOutput("midrst_complete", complete, 0);
        checkOutput("midrst_crc_ok", crc_ok, 0);
        checkOutput("midrst_end_ok", end_ok, 0);
        @(negedge clk);
        reset = 1'b1; in = 1'b1;
        applyStimulus(s, 1'b0, 4, -1);
        checkResult(s, 1'b0);

        applyStimulus(s, 1'b0, 2, 10);
        checkResult(s, 1'b0);
        checkOutput("glitch_crc_lit", crc_ok, 1);

        for (int t = 0; t < 40; t++) begin
            isLong = 1'($urandom_range(0, 1));
            s      = isLong ? makeLong() : makeShort();
            mode   = int'($urandom_range(0, 2));
            if (mode == 1) begin
                pos    = int'($urandom_range(1, isLong ? LB - 2 : SB - 2));
                s[pos] = ~s[pos];
            end else if (mode == 2) begin
                s[0] = 1'b0;
            end
            applyStimulus(s, isLong, int'($urandom_range(0, 63)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SB - 1)) : -1);
            checkResult(s, isLong);
        end

        reset = 1'b0;
        #1;
        checkOutput("donerst_out", out, 0);
        checkOutput("donerst_complete", complete, 0);
        checkOutput("donerst_crc_ok", crc_ok, 0);
        checkOutput("donerst_end_ok", end_ok, 0);
        checkOutput("donerst_timeout", timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cmd_deserializer.md
Name: cmd_deserializer

Overview:
Receives the SD card's serial response on the CMD line. It is the downstream partner of the 48-bit command serializer. It arms after a command has gone out, waits for the start bit with an NCR timeout, then shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response. It checks the CRC7 and the end bit and presents the parallel word and status flags to the command controller.

Parameters:
SHORT_BITS, 48, length of a short response including start and end bits
LONG_BITS, 136, length of a long (R2) response including start and end bits
BITS_COUNTER, 8, bit-counter width; must satisfy 2^BITS_COUNTER > LONG_BITS
TIMEOUT, 64, clock cycles to wait for the start bit (NCR limit)
TIMEOUT_COUNTER, 7, timeout-counter width; must satisfy 2^TIMEOUT_COUNTER > TIMEOUT

Ports:
clk  input  1  sampling clock, identical to the serializer clock; CMD line sampled on posedge
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  single-cycle pulse that arms reception; sampled on posedge clk
long_resp  input  1  latched on the enable edge: 1 = LONG_BITS, 0 = SHORT_BITS
in  input  1  serial CMD line from the card, idle high
out  output  LONG_BITS  received response, right-aligned; for short responses bits [LONG_BITS-1:SHORT_BITS] = 0
complete  output  1  high while in DONE (reception finished or timed out)
crc_ok  output  1  CRC7 matched; valid only when complete=1
end_ok  output  1  end bit was 1; valid only when complete=1
timeout  output  1  no start bit seen within TIMEOUT cycles; valid only when complete=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; out=0; complete=0; crc_ok=0; end_ok=0; timeout=0.
  - Bit counter, timeout counter and CRC register cleared.
  - Reset asserted mid-reception aborts immediately; no partial result is reported.
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE, or DONE with enable=1:
  - Go to WAIT_START next edge; latch long_resp.
  - Clear out, all flags, the timeout counter and the CRC register.
  - N = LONG_BITS or SHORT_BITS per long_resp.
- WAIT_START:
  - Each edge with in=1 increments the timeout counter.
  - If the counter reaches TIMEOUT: timeout=1, complete=1, go to DONE; out stays 0.
  - First edge with in=0: that 0 is the start bit; shift it in and set bit count=1; go to RECEIVE.
  - If the start bit and the TIMEOUT-th idle sample coincide, the start bit wins.
- RECEIVE:
  - Every edge: out <= {out[LONG_BITS-2:0], in}; count increments.
  - CRC7 (poly x^7+x^3+1, init 0) is updated on:
    - short: stream bits N-1 down to 8 (start, transmission, index, argument);
    - long: bits 127 down to 8 (the CID/CSD content only; the 8 header bits are excluded).
  - Bits 7..1 are compared with the CRC register.
  - On the edge that samples bit 0 (count reaches N):
    - end_ok = in;
    - crc_ok = (received bits 7..1 == computed CRC);
    - complete=1; go to DONE.
  - Total: N sampling edges from the start bit inclusive; complete is visible the cycle after the end-bit edge.
- DONE:
  - out and all flags hold until the next enable or reset.
  - The line is ignored.
- enable while in WAIT_START or RECEIVE is ignored; no restart, no corruption.
- long_resp changes outside the enable edge have no effect.
- No check of the transmission bit or command index; this belongs to the controller.
- crc_ok is reported for R3 too; the controller ignores it (R3 CRC field is 1111111).

Test Plan:
- Short response, correct CRC: enable with long_resp=0; idle 5 cycles, then shift 0x48000001AA87 MSB first -> complete rises after 48 sampling edges; out[47:0]=0x48000001AA87, upper bits 0; crc_ok=1, end_ok=1, timeout=0.
- CRC error: stream 0x48000001AA89 -> complete=1, crc_ok=0, end_ok=1; out[47:0]=0x48000001AA89.
- End-bit error: stream 0x48000001AA86 -> crc_ok=1, end_ok=0.
- Timeout: enable, hold in=1 -> after exactly 64 edges complete=1, timeout=1, out=0.
- Start bit on the 64th edge: start bit wins, reception completes normally with timeout=0.
- Long response: long_resp=1; 136-bit R2 with CRC7 from the bench model over bits 127..8 -> complete after 136 edges, out equals stream, crc_ok=1; flip bit 60 -> crc_ok=0.
- Reset mid-receive: assert reset=0 at bit 20 -> all outputs 0 asynchronously; release, re-enable, send 0x48000001AA87 -> correct result.
- enable pulsed at bit 10 of reception -> ignored; result identical to the clean run.
